// File: rtl/seq_pkg.sv
// Shared types and constants for the round-robin serial 10010 scanner.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } arb_state_e;

  typedef enum logic [2:0] {
    DetIdle,
    Det1,
    Det10,
    Det100,
    Det1001
  } det_state_e;

  localparam logic [4:0]  PATTERN    = 5'b10010;
  localparam int unsigned PAT_LEN    = 5;
  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned WORD_W_DEF = 8;

endpackage

// File: rtl/pat_det.sv
// Serial overlapping 10010 detector; hit flags the bit that completes the pattern.
module pat_det
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_in,
  output logic hit
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DetIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign hit = bit_vld && (state_q == Det1001) && (bit_in == PATTERN[0]);

  // After a hit the trailing "10" is kept so overlapping matches are counted.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DetIdle;
    end else if (bit_vld) begin
      case (state_q)
        DetIdle: state_d = bit_in ? Det1    : DetIdle;
        Det1:    state_d = bit_in ? Det1    : Det10;
        Det10:   state_d = bit_in ? Det1    : Det100;
        Det100:  state_d = bit_in ? Det1001 : DetIdle;
        Det1001: state_d = bit_in ? Det1    : Det10;
        default: state_d = DetIdle;
      endcase
    end
  end

endmodule

// File: rtl/seq_scan_arb.sv
// Round-robin arbiter sharing one serial 10010 detector; scans one word MSB first per grant
// and reports the hit count with a one-cycle done strobe.
module seq_scan_arb
  import seq_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*WORD_W-1:0]      req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_REQ)-1:0]     done_id,
  output logic [$clog2(WORD_W):0]      match_cnt
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(WORD_W) + 1;

  arb_state_e        state_q, state_d;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdW-1:0]    done_id_q, done_id_d;
  logic [CntW-1:0]   match_cnt_q, match_cnt_d;

  logic              grant_vld;
  logic [IdW-1:0]    grant_idx;
  logic [IdW:0]      cand;
  logic              accept;
  logic              det_vld;
  logic              det_hit;

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IdW + 1)'(N_REQ - 1 - k);
      if (cand >= (IdW + 1)'(N_REQ)) begin
        cand = cand - (IdW + 1)'(N_REQ);
      end
      if (req_valid[cand[IdW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    data_d      = data_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    accept      = 1'b0;
    det_vld     = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_vld && !rst) begin
          accept    = 1'b1;
          state_d   = StShift;
          id_d      = grant_idx;
          data_d    = req_data[int'(grant_idx) * WORD_W +: WORD_W];
          bit_cnt_d = '0;
          cnt_d     = '0;
          ptr_d     = (grant_idx == IdW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      StShift: begin
        det_vld   = 1'b1;
        data_d    = data_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (det_hit && (cnt_q != {CntW{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bit_cnt_q == CntW'(WORD_W - 1)) begin
          state_d     = StReport;
          done_id_d   = id_q;
          match_cnt_d = cnt_d;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      data_q      <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  pat_det u_pat_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .bit_vld (det_vld),
    .bit_in  (data_q[WORD_W-1]),
    .hit     (det_hit)
  );

  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StReport);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_scan_arb.sv
// Bench for seq_scan_arb: directed table, multi-cycle corner sequences, and random traffic
// checked every cycle against a transaction-level reference model.
module tb_seq_scan_arb;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int W16 = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           busy, done;
  logic [1:0]     done_id;
  logic [3:0]     match_cnt;

  logic [1:0]     v16 = '0;
  logic [31:0]    d16 = '0;
  logic [1:0]     r16;
  logic           b16, dn16;
  logic [0:0]     id16;
  logic [4:0]     mc16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_scan_arb #(.N_REQ(N), .WORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  seq_scan_arb #(.N_REQ(2), .WORD_W(W16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (v16),
    .req_data  (d16),
    .req_ready (r16),
    .busy      (b16),
    .done      (dn16),
    .done_id   (id16),
    .match_cnt (mc16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count windows equal to 10010 reading the word MSB first.
  function automatic int ref_hits(input logic [15:0] w, input int width);
    int n = 0;
    for (int i = width - 1; i >= 4; i--) begin
      if ({w[i], w[i-1], w[i-2], w[i-3], w[i-4]} == 5'b10010) n++;
    end
    return n;
  endfunction

  // Reference model: m_left counts cycles of busy remaining; m_id/m_cnt are the reported result.
  int           m_left = 0, m_ptr = 0, m_id = 0, m_cnt = 0, p_id = 0, p_cnt = 0, m_win;
  logic [N-1:0] m_ready;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_match_cnt", match_cnt, 0);
      m_left = 0; m_ptr = 0; m_id = 0; m_cnt = 0;
    end else begin
      m_ready = '0;
      m_win   = -1;
      if (m_left == 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
      end
      if (m_win >= 0) m_ready[m_win] = 1'b1;
      chk("model_ready", req_ready, m_ready);
      chk("model_busy", busy, m_left > 0);
      chk("model_done", done, m_left == 1);
      chk("model_done_id", done_id, m_id);
      chk("model_match_cnt", match_cnt, m_cnt);
      if (m_left > 0) begin
        if (m_left == 2) begin
          m_id  = p_id;
          m_cnt = p_cnt;
        end
        m_left--;
      end else if (m_win >= 0) begin
        m_left = W + 1;
        p_id   = m_win;
        p_cnt  = ref_hits({8'h00, req_data[m_win*W +: W]}, W);
        m_ptr  = (m_win + 1) % N;
      end
    end
  end

  task automatic wait_ready(input int r, output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_done(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    chk("idle_reached", ok, 1);
  endtask

  function automatic logic [7:0] rand_word();
    logic [7:0] base;
    case ($urandom_range(0, 2))
      0:       base = 8'($urandom);
      1:       base = 8'b10010010 ^ (8'd1 << $urandom_range(0, 7));
      default: base = 8'b01001001 ^ (8'd1 << $urandom_range(0, 7));
    endcase
    return base;
  endfunction

  typedef struct {
    int         r;
    logic [7:0] w;
    int         cnt;
  } vec_t;

  vec_t         vecs[8];
  int           t0, t1, got;
  bit           ok;
  int           rr_id[4], rr_t[4];
  logic [N-1:0] seen;

  initial begin
    vecs[0] = '{0, 8'b10010010, 2};
    vecs[1] = '{1, 8'b10010000, 1};
    vecs[2] = '{2, 8'hFF,       0};
    vecs[3] = '{3, 8'h00,       0};
    vecs[4] = '{0, 8'h09,       0};  // ends in 1001 ...
    vecs[5] = '{0, 8'h40,       0};  // ... and this one starts with 0: no cross-word hit
    vecs[6] = '{2, 8'b01001001, 1};
    vecs[7] = '{3, 8'b10010011, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_ready", req_ready, 0);
    rst = 1'b0;

    foreach (vecs[j]) begin
      @(posedge clk); #1;
      req_valid[vecs[j].r] = 1'b1;
      req_data[vecs[j].r*W +: W] = vecs[j].w;
      wait_ready(vecs[j].r, t0, ok);
      chk("tbl_ready_seen", ok, 1);
      @(posedge clk); #1;
      req_valid[vecs[j].r] = 1'b0;
      wait_done(t1, ok);
      chk("tbl_done_seen", ok, 1);
      chk("tbl_latency", t1 - t0, W + 1);
      chk("tbl_done_id", done_id, vecs[j].r);
      chk("tbl_match_cnt", match_cnt, vecs[j].cnt);
    end

    // All four requesters valid together straight out of reset.
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '1;
    req_data = {8'b10010010, 8'h00, 8'hFF, 8'b10010000};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got = 0;
    for (int i = 0; i < 80 && got < 4; i++) begin
      @(negedge clk);
      seen = req_ready;
      if (seen != '0) begin
        for (int k = 0; k < N; k++) if (seen[k]) rr_id[got] = k;
        rr_t[got] = cyc;
        got++;
        @(posedge clk); #1;
        req_valid = req_valid & ~seen;
      end
    end
    chk("rr_grants", got, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", rr_id[i], i);
    for (int i = 1; i < 4; i++) chk("rr_gap", rr_t[i] - rr_t[i-1], W + 2);
    wait_idle();

    // Reset during the 4th SHIFT cycle with another request pending.
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'b10010010;
    wait_ready(1, t0, ok);
    chk("abort_ready_seen", ok, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h92;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_async_busy", busy, 0);
    chk("abort_async_done_id", done_id, 0);
    chk("abort_async_match_cnt", match_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_first_edge_ready", req_ready, 4'b0100);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_done(t1, ok);
    chk("abort_done_seen", ok, 1);
    chk("abort_latency", t1 - t0, W + 1);
    chk("abort_done_id", done_id, 2);
    chk("abort_match_cnt", match_cnt, 2);
    wait_idle();

    // Wide-word instance.
    @(posedge clk); #1;
    v16 = 2'b01;
    d16[15:0] = 16'b1001001001001001;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (r16[0]) begin ok = 1'b1; t0 = cyc; end
    end
    chk("w16_ready_seen", ok, 1);
    @(posedge clk); #1;
    v16 = 2'b00;
    @(negedge clk);
    chk("w16_busy", b16, 1);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (dn16) begin ok = 1'b1; t1 = cyc; end
      else @(negedge clk);
    end
    chk("w16_done_seen", ok, 1);
    chk("w16_latency", t1 - t0, W16 + 1);
    chk("w16_match_cnt", mc16, 4);
    chk("w16_done_id", id16, 0);

    // Random traffic; the model above checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      seen = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (seen[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_data[i*W +: W] = rand_word();
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = rand_word();
        end
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    req_valid = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_arb.md
SEQ_SCAN_ARB -- requirements
Module: seq_scan_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning bits per scanned word (5..16).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  N_REQ  per-requester word-valid.
REQ-006 Port: req_data  input  N_REQ*WORD_W  packed words; requester i occupies bits [i*WORD_W +: WORD_W].
REQ-007 Port: req_ready  output  N_REQ  one-hot acceptance pulse.
REQ-008 Port: busy  output  1  high while a word is being scanned or reported.
REQ-009 Port: done  output  1  one-cycle result strobe.
REQ-010 Port: done_id  output  $clog2(N_REQ)  index of the requester whose result is on the outputs.
REQ-011 Port: match_cnt  output  $clog2(WORD_W)+1  number of pattern hits in the word.

Function
REQ-012 The block SHALL share one serial 10010 detector between N_REQ requesters, using round-robin arbitration.
REQ-013 FSM states SHALL be IDLE, SHIFT and REPORT.
- IDLE -> SHIFT when any req_valid is high.
- SHIFT -> REPORT after WORD_W bits.
- REPORT -> IDLE unconditionally.
REQ-014 In IDLE with any req_valid high, the block SHALL do the following in the same cycle:
- select a winner;
- assert req_ready[winner] for exactly that cycle;
- latch req_data[winner] and the winner index.
REQ-015 Round-robin search SHALL start at (last_grant+1) mod N_REQ and wrap; after reset the search starts at index 0.
REQ-016 A requester SHALL hold req_valid and its data stable until its req_ready pulse; the block SHALL never assert req_ready outside IDLE.
REQ-017 In SHIFT, one bit per cycle SHALL be fed to the detector, MSB first, for exactly WORD_W cycles.
REQ-018 The detector SHALL be cleared to its idle state on the acceptance cycle, so no match spans two words.
REQ-019 Hits SHALL be overlapping; a hit occurs on the bit that completes 1-0-0-1-0 in shift order.
REQ-020 match_cnt SHALL increment by one in the cycle each hit bit is shifted; it SHALL start from 0 for every word and saturate at its maximum.
REQ-021 In REPORT, done SHALL be 1 for exactly one cycle, with done_id and match_cnt valid in that cycle.
REQ-022 done_id and match_cnt SHALL hold their values until the next REPORT.
REQ-023 Latency from the req_ready cycle to the done cycle SHALL be WORD_W+1 cycles.
REQ-024 The next acceptance SHALL occur no earlier than the cycle after done, giving a throughput of one word per WORD_W+2 cycles.
REQ-025 busy SHALL be 1 in SHIFT and REPORT, and 0 in IDLE.
REQ-026 Requests arriving during SHIFT or REPORT SHALL wait, with no loss and no reordering within the round-robin order.
REQ-027 If req_valid of the winner drops on the acceptance cycle, the word SHALL still be processed, because acceptance is registered at the edge.

Reset
REQ-028 While rst is high, the block SHALL hold the following values: state IDLE, req_ready 0, busy 0, done 0, done_id 0, match_cnt 0, detector idle, round-robin pointer 0.
REQ-029 Reset asserted mid-SHIFT or mid-REPORT SHALL abort the word immediately; no done SHALL follow after release.
REQ-030 The first rising edge after rst falls SHALL be able to accept a request.

Structure
REQ-031 Package seq_pkg SHALL hold the following:
- FSM state enum;
- PATTERN = 5'b10010 and PAT_LEN = 5;
- default N_REQ and WORD_W.
REQ-032 The detector SHALL be a separate sub-module, pat_det, with the following behaviour:
- ports: clk, rst, clr, bit_vld, bit_in, hit;
- hit is combinational from the current state and bit_in, qualified by bit_vld;
- the default case of the state machine returns to idle.
REQ-033 The arbiter and shift counter SHALL reside in seq_scan_arb; the counter width is $clog2(WORD_W)+1.

Verification
REQ-034 req0 sends 8'b10010010 -> req_ready[0] pulses; done 9 cycles later; done_id=0, match_cnt=2.
REQ-035 req1 sends 8'b10010000 -> match_cnt=1; req2 sends 8'hFF -> match_cnt=0; req3 sends 8'h00 -> match_cnt=0.
REQ-036 All four requesters valid at the same time after reset -> grants in order 0,1,2,3, spaced 10 cycles apart.
REQ-037 Cross-word case: req0 sends 8'bxxxx1001, then the next word begins with 0 -> no hit counted for the second word's first bit.
REQ-038 rst pulses during the 4th SHIFT cycle -> all outputs go to 0 asynchronously; no done pulse; a pending request is accepted on the first edge after release.
REQ-039 With WORD_W=16, input 16'b1001001001001001 -> match_cnt=4, and done arrives 17 cycles after req_ready.
